fairy_mem_stage: RTL and testbench

FAIRY_MEM_STAGE -- requirements
Module: fairy_mem_stage

---
 rtl/fairy_mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_fairy_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fairy_mem_stage.sv
// fairy_mem_stage: pipeline memory stage. Decodes load/store opcodes, runs a
// request/response handshake on the data SRAM port, extracts and extends load
// data, flags misaligned accesses and registers results towards writeback.
module fairy_mem_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        overflow_i,
  input  logic        exception_i,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        stall_o,
  output logic [31:0] data_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        overflow_o,
  output logic        adel_o,
  output logic        ades_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state;
  logic        cancel;

  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        sgn;
  logic        mem_op;
  logic        misaligned;
  logic        mem_go;

  logic [31:0] nxt_data;
  logic [31:0] nxt_inst;
  logic [31:0] nxt_pc;
  logic        nxt_overflow;
  logic        nxt_adel;
  logic        nxt_ades;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strobe(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data replicated across all lanes so the strobes pick the right bytes.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] v);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{v[7:0]}};
      SZ_HALF: w = {2{v[15:0]}};
      default: w = v;
    endcase
    return w;
  endfunction

  // Select the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = sx ? {{24{b[7]}}, b} : {24'h000000, b};
      SZ_HALF: r = sx ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Opcode decode into load/store class, access size and signedness.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    sgn      = 1'b0;
    case (inst_i[31:26])
      6'b100000: begin is_load  = 1'b1; size = SZ_BYTE; sgn = 1'b1; end
      6'b100100: begin is_load  = 1'b1; size = SZ_BYTE; sgn = 1'b0; end
      6'b100001: begin is_load  = 1'b1; size = SZ_HALF; sgn = 1'b1; end
      6'b100101: begin is_load  = 1'b1; size = SZ_HALF; sgn = 1'b0; end
      6'b100011: begin is_load  = 1'b1; size = SZ_WORD; sgn = 1'b0; end
      6'b101000: begin is_store = 1'b1; size = SZ_BYTE; end
      6'b101001: begin is_store = 1'b1; size = SZ_HALF; end
      6'b101011: begin is_store = 1'b1; size = SZ_WORD; end
      default:   begin is_load  = 1'b0; is_store = 1'b0; end
    endcase
  end

  assign mem_op     = is_load | is_store;
  assign misaligned = ((size == SZ_HALF) && data_i[0]) ||
                      ((size == SZ_WORD) && (data_i[1:0] != 2'b00));
  assign mem_go     = mem_op & ~misaligned & ~exception_i;

  // SRAM request fields come straight from the held inputs, so they stay
  // stable for as long as the stage stalls in REQ.
  assign data_sram_req   = (state == REQ);
  assign data_sram_wr    = is_store;
  assign data_sram_addr  = {data_i[31:2], 2'b00};
  assign data_sram_wstrb = is_store ? store_strobe(size, data_i[1:0]) : 4'b0000;
  assign data_sram_wdata = store_data(size, op1_i);

  assign stall_o = ((state == IDLE) && mem_go) ||
                   (state == REQ) ||
                   ((state == WAIT) && !data_sram_data_ok);

  // Handshake FSM plus the cancel flag for responses that must be discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cancel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (mem_go) state <= REQ;
          else        state <= IDLE;
        end
        REQ: begin
          // data_ok is ignored here; only the acceptance moves us on.
          if (data_sram_addr_ok)  state <= WAIT;
          else if (exception_i)   state <= IDLE;
          else                    state <= REQ;
        end
        WAIT: begin
          if (data_sram_data_ok) begin
            state  <= IDLE;
            cancel <= 1'b0;
          end else begin
            state  <= WAIT;
            cancel <= cancel | exception_i;
          end
        end
        default: begin
          state  <= IDLE;
          cancel <= 1'b0;
        end
      endcase
    end
  end

  // Next writeback values: completion, pass-through, or bubble by default.
  always_comb begin
    nxt_data     = 32'h0000_0000;
    nxt_inst     = 32'h0000_0000;
    nxt_pc       = 32'h0000_0000;
    nxt_overflow = 1'b0;
    nxt_adel     = 1'b0;
    nxt_ades     = 1'b0;
    if ((state == WAIT) && data_sram_data_ok) begin
      if (!(cancel || exception_i)) begin
        nxt_data     = is_load ? load_extract(data_sram_rdata, data_i[1:0], size, sgn) : data_i;
        nxt_inst     = inst_i;
        nxt_pc       = pc_i;
        nxt_overflow = overflow_i;
      end else begin
        nxt_data     = 32'h0000_0000;
      end
    end else if (!stall_o && !exception_i) begin
      nxt_data     = data_i;
      nxt_inst     = inst_i;
      nxt_pc       = pc_i;
      nxt_overflow = overflow_i;
      nxt_adel     = is_load & misaligned;
      nxt_ades     = is_store & misaligned;
    end else begin
      nxt_data     = 32'h0000_0000;
    end
  end

  // Writeback output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o     <= 32'h0000_0000;
      inst_o     <= 32'h0000_0000;
      pc_o       <= 32'h0000_0000;
      overflow_o <= 1'b0;
      adel_o     <= 1'b0;
      ades_o     <= 1'b0;
    end else begin
      data_o     <= nxt_data;
      inst_o     <= nxt_inst;
      pc_o       <= nxt_pc;
      overflow_o <= nxt_overflow;
      adel_o     <= nxt_adel;
      ades_o     <= nxt_ades;
    end
  end

endmodule

// File: tb/tb_fairy_mem_stage.sv
// Scoreboard bench for fairy_mem_stage: the driver pushes one expected record
// per cycle; the monitor checks combinational outputs at the falling edge and
// registered outputs just after the following rising edge.
module tb_fairy_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_i = 32'h0, op1_i = 32'h0, inst_i = 32'h0, pc_i = 32'h0;
  logic        overflow_i = 1'b0, exception_i = 1'b0;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = 32'h0;
  logic        stall_o;
  logic [31:0] data_o, inst_o, pc_o;
  logic        overflow_o, adel_o, ades_o;

  fairy_mem_stage dut (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .op1_i(op1_i), .inst_i(inst_i),
    .pc_i(pc_i), .overflow_i(overflow_i), .exception_i(exception_i),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .stall_o(stall_o), .data_o(data_o), .inst_o(inst_o), .pc_o(pc_o),
    .overflow_o(overflow_o), .adel_o(adel_o), .ades_o(ades_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDU = 32'h0085_1021;
  localparam logic [31:0] I_ADD  = 32'h0085_1020;
  localparam logic [31:0] I_LB   = 32'h8082_0003;
  localparam logic [31:0] I_LBU  = 32'h9082_0001;
  localparam logic [31:0] I_LH   = 32'h8482_0006;
  localparam logic [31:0] I_LHU  = 32'h9482_0402;
  localparam logic [31:0] I_LW   = 32'h8C82_0001;
  localparam logic [31:0] I_SB   = 32'hA082_0005;
  localparam logic [31:0] I_SH   = 32'hA482_0002;
  localparam logic [31:0] I_SW   = 32'hAC82_0002;

  typedef struct {
    logic        chk_stall;
    logic        stall;
    logic        req;
    logic        chk_sram;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic [31:0] data, inst, pc;
    logic        ovf, adel, ades;
  } rec_t;

  rec_t q[$];
  rec_t nx;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        s_rst = 1'b0;
  logic [31:0] s_data, s_op1, s_inst, s_pc, s_rdata;
  logic        s_ovf, s_exc, s_aok, s_dok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [31:0] d, input logic [31:0] op1, input logic [31:0] inst,
                        input logic [31:0] pc, input logic ovf, input logic exc,
                        input logic aok, input logic dok, input logic [31:0] rd);
    s_data = d; s_op1 = op1; s_inst = inst; s_pc = pc; s_ovf = ovf;
    s_exc = exc; s_aok = aok; s_dok = dok; s_rdata = rd;
  endtask

  task automatic exp_c(input logic cs, input logic st, input logic rq);
    nx.chk_stall = cs; nx.stall = st; nx.req = rq;
    nx.chk_sram = 1'b0; nx.chk_wdata = 1'b0;
    nx.wr = 1'b0; nx.wstrb = 4'h0; nx.addr = 32'h0; nx.wdata = 32'h0;
  endtask

  task automatic exp_s(input logic wr, input logic [3:0] ws, input logic [31:0] ad,
                       input logic cw, input logic [31:0] wd);
    nx.chk_sram = 1'b1; nx.wr = wr; nx.wstrb = ws; nx.addr = ad;
    nx.chk_wdata = cw; nx.wdata = wd;
  endtask

  task automatic exp_r(input logic [31:0] d, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ovf, input logic adel, input logic ades);
    nx.data = d; nx.inst = inst; nx.pc = pc; nx.ovf = ovf; nx.adel = adel; nx.ades = ades;
  endtask

  task automatic bubble();
    exp_r(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Apply staged inputs just after the rising edge and queue their expectation.
  task automatic tick();
    @(posedge clk);
    #1;
    reset_n = s_rst; data_i = s_data; op1_i = s_op1; inst_i = s_inst; pc_i = s_pc;
    overflow_i = s_ovf; exception_i = s_exc; data_sram_addr_ok = s_aok;
    data_sram_data_ok = s_dok; data_sram_rdata = s_rdata;
    q.push_back(nx);
  endtask

  // Monitor: combinational checks mid-cycle, registered checks after the edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q[0];
        if (r.chk_stall) chk("stall_o", 32'(stall_o), 32'(r.stall));
        chk("data_sram_req", 32'(data_sram_req), 32'(r.req));
        if (r.chk_sram) begin
          chk("data_sram_wr", 32'(data_sram_wr), 32'(r.wr));
          chk("data_sram_wstrb", 32'(data_sram_wstrb), 32'(r.wstrb));
          chk("data_sram_addr", data_sram_addr, r.addr);
          if (r.chk_wdata) chk("data_sram_wdata", data_sram_wdata, r.wdata);
        end
        @(posedge clk);
        #2;
        chk("data_o", data_o, r.data);
        chk("inst_o", inst_o, r.inst);
        chk("pc_o", pc_o, r.pc);
        chk("overflow_o", 32'(overflow_o), 32'(r.ovf));
        chk("adel_o", 32'(adel_o), 32'(r.adel));
        chk("ades_o", 32'(ades_o), 32'(r.ades));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    // Reset state
    s_rst = 1'b0;
    set_in(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); bubble(); tick();
    s_rst = 1'b1;

    // Non-memory pass-through, overflow, exception in IDLE
    set_in(32'h1234, 32'h0, I_ADDU, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h1234, I_ADDU, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0); tick();
    set_in(32'h7FFF_0000, 32'h0, I_ADD, 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h7FFF_0000, I_ADD, 32'hBFC0_0004, 1'b1, 1'b0, 1'b0); tick();
    set_in(32'h99, 32'h0, I_ADDU, 32'hBFC0_0008, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); bubble(); tick();

    // LB 0x103: addr_ok on second REQ cycle, data_ok on third WAIT cycle
    set_in(32'h103, 32'h0, I_LB, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h100, 1'b0, 32'h0); bubble(); tick();
    s_aok = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h100, 1'b0, 32'h0); bubble(); tick();
    s_aok = 1'b0;
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_dok = 1'b1; s_rdata = 32'h80FF_FFFF;
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'hFFFF_FF80, I_LB, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0); tick();

    // SH 0x202 with addr_ok and data_ok together in REQ
    set_in(32'h202, 32'hAAAA_BEEF, I_SH, 32'hBFC0_0014, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_aok = 1'b1; s_dok = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b1, 4'b1100, 32'h200, 1'b1, 32'hBEEF_BEEF); bubble(); tick();
    s_aok = 1'b0; s_dok = 1'b0;
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_dok = 1'b1;
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h202, I_SH, 32'hBFC0_0014, 1'b0, 1'b0, 1'b0); tick();

    // Misaligned LW and SW: no request, error flag, bad address on data_o
    set_in(32'h301, 32'h0, I_LW, 32'hBFC0_0018, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h301, I_LW, 32'hBFC0_0018, 1'b0, 1'b1, 1'b0); tick();
    set_in(32'h302, 32'h1, I_SW, 32'hBFC0_001C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h302, I_SW, 32'hBFC0_001C, 1'b0, 1'b0, 1'b1); tick();

    // SB 0x105
    set_in(32'h105, 32'h1234_56A5, I_SB, 32'hBFC0_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_aok = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b1, 4'b0010, 32'h104, 1'b1, 32'hA5A5_A5A5); bubble(); tick();
    s_aok = 1'b0; s_dok = 1'b1;
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h105, I_SB, 32'hBFC0_0020, 1'b0, 1'b0, 1'b0); tick();

    // LH 0x106 (upper half, sign-extended) and LBU 0x101 (zero-extended)
    set_in(32'h106, 32'h0, I_LH, 32'hBFC0_0024, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8001_7FFF);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_aok = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h104, 1'b0, 32'h0); bubble(); tick();
    s_aok = 1'b0; s_dok = 1'b1;
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'hFFFF_8001, I_LH, 32'hBFC0_0024, 1'b0, 1'b0, 1'b0); tick();
    set_in(32'h101, 32'h0, I_LBU, 32'hBFC0_0028, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_80CD);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_aok = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h100, 1'b0, 32'h0); bubble(); tick();
    s_aok = 1'b0; s_dok = 1'b1;
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h0000_0080, I_LBU, 32'hBFC0_0028, 1'b0, 1'b0, 1'b0); tick();

    // LHU 0x402: exception in WAIT cancels the result
    set_in(32'h402, 32'h0, I_LHU, 32'hBFC0_002C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_aok = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h400, 1'b0, 32'h0); bubble(); tick();
    s_aok = 1'b0; s_exc = 1'b1;
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_exc = 1'b0; s_dok = 1'b1; s_rdata = 32'h8001_0000;
    exp_c(1'b1, 1'b0, 1'b0); bubble(); tick();
    set_in(32'h55, 32'h0, I_ADDU, 32'hBFC0_0030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h55, I_ADDU, 32'hBFC0_0030, 1'b0, 1'b0, 1'b0); tick();

    // LW 0x500: exception in REQ without acceptance drops the request
    set_in(32'h500, 32'h0, I_LW, 32'hBFC0_0034, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    s_exc = 1'b1;
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h500, 1'b0, 32'h0); bubble(); tick();
    set_in(32'h66, 32'h0, I_ADDU, 32'hBFC0_0038, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h66, I_ADDU, 32'hBFC0_0038, 1'b0, 1'b0, 1'b0); tick();

    // LW 0x600: reset asserted while in REQ, stray data_ok after release
    set_in(32'h600, 32'h0, I_LW, 32'hBFC0_003C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_c(1'b1, 1'b1, 1'b0); bubble(); tick();
    exp_c(1'b1, 1'b1, 1'b1); exp_s(1'b0, 4'b0000, 32'h600, 1'b0, 32'h0); bubble(); tick();
    s_rst = 1'b0;
    exp_c(1'b0, 1'b0, 1'b0); bubble(); tick();
    s_rst = 1'b1;
    set_in(32'h77, 32'h0, I_ADDU, 32'hBFC0_0040, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    exp_c(1'b1, 1'b0, 1'b0); exp_r(32'h77, I_ADDU, 32'hBFC0_0040, 1'b0, 1'b0, 1'b0); tick();
    set_in(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
